// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_NEG   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SELBA = 4'h6;
  localparam logic [3:0] OP_SELAB = 4'h7;
  localparam logic [3:0] OP_SUB   = 4'h8;
  localparam logic [3:0] OP_LT    = 4'h9;
  localparam logic [3:0] OP_LE    = 4'hA;
  localparam logic [3:0] OP_GT    = 4'hB;
  localparam logic [3:0] OP_GE    = 4'hC;
  localparam logic [3:0] OP_EQ    = 4'hD;
  localparam logic [3:0] OP_NE    = 4'hE;
  localparam logic [3:0] OP_XSB   = 4'hF;

  localparam int FLG_ZF = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_V  = 3;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath for the 16-opcode set; flag outputs exist only
// when ALU_PIPE_FLAGS_EN is defined.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   inst_i,
  input  logic         sel_i,
  output logic [W-1:0] res_o
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]   flags_o
`endif
);

  logic signed [W-1:0] a_s;
  logic signed [W-1:0] b_s;
  logic [W-1:0]        add_x;
  logic [W-1:0]        add_y;
  logic [W-1:0]        sum;
  logic                add_cin;

  assign a_s = a_i;
  assign b_s = b_i;

  // ADD, NEG and SUB share one adder: NEG is ~A+0+1, SUB is A+~B+1.
  always_comb begin
    add_x   = a_i;
    add_y   = b_i;
    add_cin = 1'b0;
    case (inst_i)
      OP_NEG: begin
        add_x   = ~a_i;
        add_y   = '0;
        add_cin = 1'b1;
      end
      OP_SUB: begin
        add_y   = ~b_i;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic [W:0] sum_c;
  logic       arith;

  function automatic logic [3:0] calc_flags(input logic [W-1:0] r,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic         cout,
                                            input logic         is_arith);
    logic [3:0] f;
    f         = '0;
    f[FLG_ZF] = (r == '0);
    f[FLG_N]  = r[W-1];
    if (is_arith) begin
      f[FLG_C] = cout;
      f[FLG_V] = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return f;
  endfunction

  assign sum_c   = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
  assign sum     = sum_c[W-1:0];
  assign arith   = (inst_i == OP_ADD) || (inst_i == OP_NEG) || (inst_i == OP_SUB);
  assign flags_o = calc_flags(res_o, add_x, add_y, sum_c[W], arith);
`else
  assign sum = add_x + add_y + {{(W-1){1'b0}}, add_cin};
`endif

  always_comb begin
    res_o = '0;
    case (inst_i)
      OP_ADD, OP_NEG, OP_SUB: res_o = sum;
      OP_AND:   res_o = a_i & b_i;
      OP_OR:    res_o = a_i | b_i;
      OP_XOR:   res_o = a_i ^ b_i;
      OP_NOT:   res_o = ~a_i;
      OP_SELBA: res_o = sel_i ? b_i : a_i;
      OP_SELAB: res_o = sel_i ? a_i : b_i;
      OP_LT:    res_o = {{(W-1){1'b0}}, (a_s <  b_s)};
      OP_LE:    res_o = {{(W-1){1'b0}}, (a_s <= b_s)};
      OP_GT:    res_o = {{(W-1){1'b0}}, (a_s >  b_s)};
      OP_GE:    res_o = {{(W-1){1'b0}}, (a_s >= b_s)};
      OP_EQ:    res_o = {{(W-1){1'b0}}, (a_s == b_s)};
      OP_NE:    res_o = {{(W-1){1'b0}}, (a_s != b_s)};
      OP_XSB:   res_o = {{(W-1){1'b0}}, (sel_i ^ b_i[0])};
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides. S1 holds operands,
// S2 holds the result. Define ALU_PIPE_FLAGS_EN to add the FLAGS output.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   INST,
  input  logic         SEL,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] Z
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]   FLAGS
`endif
);

  logic         vld_p1_q, vld_p1_d;
  logic [W-1:0] a_p1_q, a_p1_d;
  logic [W-1:0] b_p1_q, b_p1_d;
  logic [3:0]   inst_p1_q, inst_p1_d;
  logic         sel_p1_q, sel_p1_d;
  logic         vld_p2_q, vld_p2_d;
  logic [W-1:0] z_p2_q, z_p2_d;
  logic [W-1:0] core_res;
  logic         s2_free;

`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0]   flg_p2_q, flg_p2_d;
  logic [3:0]   core_flags;
`endif

  alu_pipe_core #(.W(W)) u_core (
    .a_i    (a_p1_q),
    .b_i    (b_p1_q),
    .inst_i (inst_p1_q),
    .sel_i  (sel_p1_q),
    .res_o  (core_res)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .flags_o(core_flags)
`endif
  );

  assign s2_free   = !vld_p2_q || OUT_READY;
  assign IN_READY  = !vld_p1_q || s2_free;
  assign OUT_VALID = vld_p2_q;
  assign Z         = z_p2_q;
`ifdef ALU_PIPE_FLAGS_EN
  assign FLAGS     = flg_p2_q;
`endif

  always_comb begin
    vld_p1_d  = vld_p1_q;
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    inst_p1_d = inst_p1_q;
    sel_p1_d  = sel_p1_q;
    vld_p2_d  = vld_p2_q;
    z_p2_d    = z_p2_q;
`ifdef ALU_PIPE_FLAGS_EN
    flg_p2_d  = flg_p2_q;
`endif
    // S0 -> S1: operand capture on accept
    if (IN_READY) begin
      vld_p1_d = IN_VALID;
      if (IN_VALID) begin
        a_p1_d    = A;
        b_p1_d    = B;
        inst_p1_d = INST;
        sel_p1_d  = SEL;
      end
    end
    // S1 -> S2: result capture when the output slot is free
    if (s2_free) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        z_p2_d = core_res;
`ifdef ALU_PIPE_FLAGS_EN
        flg_p2_d = core_flags;
`endif
      end
    end
  end

  // Operand registers are not reset; the visible result is cleared with the valids.
  always_ff @(posedge CLK) begin
    a_p1_q    <= a_p1_d;
    b_p1_q    <= b_p1_d;
    inst_p1_q <= inst_p1_d;
    sel_p1_q  <= sel_p1_d;
    if (RST) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      z_p2_q   <= '0;
`ifdef ALU_PIPE_FLAGS_EN
      flg_p2_q <= '0;
`endif
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      z_p2_q   <= z_p2_d;
`ifdef ALU_PIPE_FLAGS_EN
      flg_p2_q <= flg_p2_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a W=32 instance for the main scenarios and a
// W=8 instance for the narrow-width boundary cases.
module tb_alu_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, sel, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic [3:0]  inst;
  logic        in_valid8, in_ready8, sel8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, z8;
  logic [3:0]  inst8;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0]  flags, flags8;
`endif

  int nvec = 0;
  int nerr = 0;

  alu_pipe #(.W(32)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .INST(inst), .SEL(sel),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .Z(z)
`ifdef ALU_PIPE_FLAGS_EN
    , .FLAGS(flags)
`endif
  );

  alu_pipe #(.W(8)) dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .A(a8), .B(b8), .INST(inst8), .SEL(sel8),
    .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .Z(z8)
`ifdef ALU_PIPE_FLAGS_EN
    , .FLAGS(flags8)
`endif
  );

  typedef struct packed {
    logic [3:0]  op;
    logic        s;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ez;
    logic [3:0]  ef;   // {V,C,N,ZF}
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic s, input logic [31:0] va, input logic [31:0] vb);
    inst = op; sel = s; a = va; b = vb; in_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    nvec++; if (z !== 32'h0) begin nerr++; $display("FAIL rst_z got %h want 0", z); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
`ifdef ALU_PIPE_FLAGS_EN
    nvec++; if (flags !== 4'h0) begin nerr++; $display("FAIL rst_flags got %h want 0", flags); end
`endif
    tick;
    // Reset held for two cycles while traffic is in flight
    out_ready = 1'b0;
    drive(4'h0, 1'b0, 32'd1, 32'd2); tick;
    drive(4'h0, 1'b0, 32'd5, 32'd6); tick;
    rst = 1'b1; tick; tick;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    nvec++; if (z !== 32'h0) begin nerr++; $display("FAIL midrst_z got %h want 0", z); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    tick;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_after got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_add_overflow;
    out_ready = 1'b1;
    drive(4'h0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    tick;
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL add_lat1 got %b want 0", out_valid); end
    tick;
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL add_lat2 got %b want 1", out_valid); end
    nvec++; if (z !== 32'h8000_0000) begin nerr++; $display("FAIL add_z got %h want 80000000", z); end
`ifdef ALU_PIPE_FLAGS_EN
    nvec++; if (flags !== 4'b1010) begin nerr++; $display("FAIL add_flags got %b want 1010", flags); end
`endif
    tick;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL add_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got [4];
    int          at  [4];
    logic [31:0] exp_z [3];
    int          n;
    exp_z[0] = 32'h0000_00F0; exp_z[1] = 32'h0000_0001; exp_z[2] = 32'hFFFF_FFFB;
    n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive(4'h2, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0);
        1: drive(4'h9, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        2: drive(4'h1, 1'b0, 32'h0000_0005, 32'h0000_0000);
        default: in_valid = 1'b0;
      endcase
      #1;
      if (c < 3) begin
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_in_ready c=%0d got %b want 1", c, in_ready); end
      end
      if (out_valid === 1'b1) begin
        if (n < 4) begin got[n] = z; at[n] = c; end
        n++;
      end
      tick;
    end
    nvec++; if (n !== 3) begin nerr++; $display("FAIL b2b_count got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      if (i < n) begin
        nvec++; if (got[i] !== exp_z[i]) begin nerr++; $display("FAIL b2b_z[%0d] got %h want %h", i, got[i], exp_z[i]); end
        nvec++; if (at[i] !== i + 2) begin nerr++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, at[i], i + 2); end
      end
    end
  endtask

  task automatic test_opcodes;
    vec_t tbl [15];
    tbl = '{
      '{4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101},
      '{4'h1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0101},
      '{4'h3, 1'b0, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 4'b0000},
      '{4'h4, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b0010},
      '{4'h5, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987, 4'b0010},
      '{4'h6, 1'b0, 32'h0000_00AA, 32'h0000_0055, 32'h0000_00AA, 4'b0000},
      '{4'h7, 1'b0, 32'h0000_00AA, 32'h0000_0055, 32'h0000_0055, 4'b0000},
      '{4'h8, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0010},
      '{4'h9, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000},
      '{4'hA, 1'b0, 32'h0000_0003, 32'h0000_0003, 32'h0000_0001, 4'b0000},
      '{4'hB, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000},
      '{4'hC, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001},
      '{4'hD, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 4'b0000},
      '{4'hE, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 4'b0001},
      '{4'hF, 1'b0, 32'h0000_0000, 32'h0000_0003, 32'h0000_0001, 4'b0000}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].op, tbl[i].s, tbl[i].va, tbl[i].vb);
      tick;
      in_valid = 1'b0;
      tick;
      nvec++;
      if (out_valid !== 1'b1 || z !== tbl[i].ez) begin
        nerr++; $display("FAIL op%h_z got v=%b z=%h want v=1 z=%h", tbl[i].op, out_valid, z, tbl[i].ez);
      end
`ifdef ALU_PIPE_FLAGS_EN
      nvec++;
      if (flags !== tbl[i].ef) begin
        nerr++; $display("FAIL op%h_flags got %b want %b", tbl[i].op, flags, tbl[i].ef);
      end
`endif
    end
    tick;
  endtask

  task automatic test_stall;
    vec_t        ops [6];
    logic [31:0] got [8];
    int          n, sent;
    logic        fire;
    ops = '{
      '{4'h0, 1'b0, 32'd3,          32'd4,          32'h0000_0007, 4'b0},
      '{4'h8, 1'b0, 32'd10,         32'd4,          32'h0000_0006, 4'b0},
      '{4'h4, 1'b0, 32'h0000_FF00,  32'h0000_0FF0,  32'h0000_F0F0, 4'b0},
      '{4'h3, 1'b0, 32'h0000_0100,  32'h0000_0001,  32'h0000_0101, 4'b0},
      '{4'h6, 1'b1, 32'h0000_00AA,  32'h0000_0055,  32'h0000_0055, 4'b0},
      '{4'hB, 1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFB,  32'h0000_0001, 4'b0}
    };
    n = 0; sent = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c >= 4);
      if (sent < 6) drive(ops[sent].op, ops[sent].s, ops[sent].va, ops[sent].vb);
      else in_valid = 1'b0;
      #1;
      if (c == 2 || c == 3) begin
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_in_ready c=%0d got %b want 0", c, in_ready); end
        nvec++; if (out_valid !== 1'b1 || z !== 32'h7) begin nerr++; $display("FAIL stall_hold c=%0d got v=%b z=%h want v=1 z=7", c, out_valid, z); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (n < 8) got[n] = z;
        n++;
      end
      fire = in_valid && in_ready;
      tick;
      if (fire) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    nvec++; if (n !== 6) begin nerr++; $display("FAIL stall_count got %0d want 6", n); end
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        nvec++; if (got[i] !== ops[i].ez) begin nerr++; $display("FAIL stall_z[%0d] got %h want %h", i, got[i], ops[i].ez); end
      end
    end
  endtask

  task automatic test_reset_inflight;
    out_ready = 1'b0;
    drive(4'h0, 1'b0, 32'd1, 32'd1); tick;
    drive(4'h0, 1'b0, 32'd2, 32'd2); tick;
    in_valid = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL inflight_setup got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1; tick;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL inflight_rst got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL inflight_stale c=%0d got v=%b z=%h want v=0", c, out_valid, z); end
    end
  endtask

  task automatic test_w8;
    out_ready8 = 1'b1;
    inst8 = 4'h8; sel8 = 1'b0; a8 = 8'h80; b8 = 8'h01; in_valid8 = 1'b1;
    tick;
    inst8 = 4'hF; sel8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
    tick;
    in_valid8 = 1'b0;
    nvec++; if (out_valid8 !== 1'b1 || z8 !== 8'h7F) begin nerr++; $display("FAIL w8_sub got v=%b z=%h want v=1 z=7f", out_valid8, z8); end
`ifdef ALU_PIPE_FLAGS_EN
    nvec++; if (flags8 !== 4'b1100) begin nerr++; $display("FAIL w8_sub_flags got %b want 1100", flags8); end
`endif
    tick;
    nvec++; if (out_valid8 !== 1'b1 || z8 !== 8'h00) begin nerr++; $display("FAIL w8_xsb got v=%b z=%h want v=1 z=00", out_valid8, z8); end
`ifdef ALU_PIPE_FLAGS_EN
    nvec++; if (flags8 !== 4'b0001) begin nerr++; $display("FAIL w8_xsb_flags got %b want 0001", flags8); end
`endif
    tick;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; inst = '0; sel = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; inst8 = '0; sel8 = 1'b0;
    test_reset;
    test_add_overflow;
    test_back_to_back;
    test_opcodes;
    test_stall;
    test_reset_inflight;
    test_w8;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
